// File: rtl/pwconv_conv_ctrl.sv
// Pointwise-conv sequencer: walks the weight SRAM per pixel and
// presents one (valid, channel) beat per cycle to the MAC array.
module pwconv_conv_ctrl #(
   parameter int NUM_OC = 32,
   parameter int OC_W   = 5,
   parameter int PIX_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PIX_W-1:0] num_pix,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic             w_en,
   output logic [OC_W-1:0]  w_cnt,
   output logic             mac_valid,
   output logic [OC_W-1:0]  mac_oc,
   output logic             mac_first,
   output logic             mac_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PIX,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam logic [OC_W-1:0] OC_LAST = OC_W'(NUM_OC - 1);

   state_t           state, state_nx;
   logic [OC_W-1:0]  oc_cnt, oc_nx;
   logic [PIX_W-1:0] pix_cnt, pix_nx;
   logic [PIX_W-1:0] last_pix, last_nx;
   logic             issue, accept;

   assign mac_first = mac_valid && (mac_oc == '0);
   assign mac_last  = mac_valid && (mac_oc == OC_LAST);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx  = state;
      oc_nx     = oc_cnt;
      pix_nx    = pix_cnt;
      last_nx   = last_pix;
      pix_ready = 1'b0;
      done      = 1'b0;
      // A read may issue only when the beat slot is empty or draining.
      issue     = (state == RUN) && (!mac_valid || out_ready);
      accept    = mac_valid && out_ready;
      w_en      = issue;
      w_cnt     = issue ? oc_cnt : '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = WAIT_PIX;
               pix_nx   = '0;
               last_nx  = (num_pix == '0) ? '0
                        : num_pix - PIX_W'(1);
            end
         end
         WAIT_PIX: begin
            if (pix_valid) begin
               state_nx = RUN;
               oc_nx    = '0;
            end
         end
         RUN: begin
            if (issue) begin
               if (oc_cnt == OC_LAST) begin
                  state_nx = DRAIN;
               end else begin
                  oc_nx = oc_cnt + OC_W'(1);
               end
            end
         end
         DRAIN: begin
            if (accept && mac_last) begin
               pix_ready = 1'b1;
               if (pix_cnt == last_pix) begin
                  state_nx = DONE;
               end else begin
                  pix_nx   = pix_cnt + PIX_W'(1);
                  state_nx = WAIT_PIX;
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         oc_cnt    <= '0;
         pix_cnt   <= '0;
         last_pix  <= '0;
         mac_valid <= 1'b0;
         mac_oc    <= '0;
      end else begin
         state    <= state_nx;
         oc_cnt   <= oc_nx;
         pix_cnt  <= pix_nx;
         last_pix <= last_nx;
         // SRAM Q lands one cycle after the address; stalls hold the beat.
         if (issue) begin
            mac_valid <= 1'b1;
            mac_oc    <= oc_cnt;
         end else if (accept) begin
            mac_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwconv_conv_ctrl.sv
// Directed bench for pwconv_conv_ctrl: scenario table plus
// hand-written reset corner cases.
module tb_pwconv_conv_ctrl;

   localparam int NUM_OC = 32;
   localparam int OC_W   = 5;
   localparam int PIX_W  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [PIX_W-1:0] num_pix;
   logic             pix_valid;
   logic             pix_ready;
   logic             w_en;
   logic [OC_W-1:0]  w_cnt;
   logic             mac_valid;
   logic [OC_W-1:0]  mac_oc;
   logic             mac_first;
   logic             mac_last;
   logic             out_ready;
   logic             busy;
   logic             done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   pwconv_conv_ctrl #(
      .NUM_OC(NUM_OC),
      .OC_W  (OC_W),
      .PIX_W (PIX_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .num_pix  (num_pix),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .w_en     (w_en),
      .w_cnt    (w_cnt),
      .mac_valid(mac_valid),
      .mac_oc   (mac_oc),
      .mac_first(mac_first),
      .mac_last (mac_last),
      .out_ready(out_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int np;
      int stall_at;
      int stall_len;
      int gap_pix;
      int gap_len;
      int start_mid;
      int exp_beats;
      int exp_pr;
      int exp_done;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d",
                  name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_w_en"}, int'(w_en), 0);
      chk({tag, "_w_cnt"}, int'(w_cnt), 0);
      chk({tag, "_mac_valid"}, int'(mac_valid), 0);
      chk({tag, "_mac_oc"}, int'(mac_oc), 0);
      chk({tag, "_mac_first"}, int'(mac_first), 0);
      chk({tag, "_mac_last"}, int'(mac_last), 0);
      chk({tag, "_pix_ready"}, int'(pix_ready), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   task automatic run_scn(input vec_t v);
      int beats, issues, pr_cnt, done_cnt;
      int done_cyc, gap_left, first_w, first_mv, oc;
      bit fin;
      beats    = 0;
      issues   = 0;
      pr_cnt   = 0;
      done_cnt = 0;
      done_cyc = -1;
      gap_left = 0;
      first_w  = -1;
      first_mv = -1;
      fin      = 1'b0;
      num_pix  = PIX_W'(v.np);
      for (int c = 0; c < 2000 && !fin; c++) begin
         cyc       = c;
         start     = (c == 0) || (c == v.start_mid);
         out_ready = !(v.stall_len > 0 && c >= v.stall_at &&
                       c < v.stall_at + v.stall_len);
         pix_valid = (gap_left == 0);
         if (gap_left > 0) gap_left--;
         #4;
         if (c == 0) chk("busy_c0", int'(busy), 0);
         if (c == 1) chk("busy_c1", int'(busy), 1);
         if (w_en) begin
            if (first_w < 0) first_w = c;
            chk("w_cnt", int'(w_cnt), issues % NUM_OC);
            issues++;
         end else begin
            chk("w_cnt_off", int'(w_cnt), 0);
         end
         if (mac_valid) begin
            if (first_mv < 0) first_mv = c;
            oc = beats % NUM_OC;
            chk("mac_oc", int'(mac_oc), oc);
            chk("mac_first", int'(mac_first), int'(oc == 0));
            chk("mac_last", int'(mac_last), int'(oc == NUM_OC - 1));
            if (!out_ready) chk("stall_w_en", int'(w_en), 0);
            else beats++;
         end
         if (pix_ready) begin
            pr_cnt++;
            chk("pr_on_last", int'(mac_last && out_ready), 1);
            if (pr_cnt == v.gap_pix) gap_left = v.gap_len;
         end
         if (done_cyc >= 0 && c == done_cyc + 1) begin
            chk("busy_fall", int'(busy), 0);
            fin = 1'b1;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         tick();
      end
      start     = 1'b0;
      out_ready = 1'b1;
      chk("timeout", int'(fin), 1);
      chk("beats", beats, v.exp_beats);
      chk("pix_ready_cnt", pr_cnt, v.exp_pr);
      chk("done_cnt", done_cnt, 1);
      chk("done_cycle", done_cyc, v.exp_done);
      chk("first_w_en", first_w, 2);
      chk("first_mac_valid", first_mv, 3);
   endtask

   initial begin
      // np stall_at stall_len gap_pix gap_len start_mid beats pr done
      tbl[0] = '{1, 0, 0, 0, 0, -1, 32, 1, 35};
      tbl[1] = '{1, 10, 3, 0, 0, -1, 32, 1, 38};
      tbl[2] = '{3, 0, 0, 2, 5, -1, 96, 3, 108};
      tbl[3] = '{0, 0, 0, 0, 0, -1, 32, 1, 35};
      tbl[4] = '{1, 0, 0, 0, 0, 15, 32, 1, 35};
      tbl[5] = '{2, 34, 2, 0, 0, -1, 64, 2, 71};

      rst       = 1'b1;
      start     = 1'b0;
      pix_valid = 1'b0;
      out_ready = 1'b1;
      num_pix   = '0;
      tick();
      tick();
      tick();
      #4;
      chk_idle("reset");
      tick();
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_scn(tbl[i]);
         tick();
      end

      num_pix   = PIX_W'(1);
      pix_valid = 1'b1;
      out_ready = 1'b1;
      begin
         bit hit;
         hit = 1'b0;
         for (int c = 0; c < 100 && !hit; c++) begin
            cyc   = c;
            start = (c == 0);
            #4;
            if (mac_valid && mac_oc == OC_W'(15)) hit = 1'b1;
            else tick();
         end
         chk("rst_mid_reach", int'(hit), 1);
         chk("rst_mid_cycle", cyc, 18);
      end
      start = 1'b0;
      rst   = 1'b1;
      tick();
      rst = 1'b0;
      #4;
      chk_idle("rst_mid");
      for (int c = 0; c < 10; c++) begin
         tick();
         #4;
         chk("rst_no_done", int'(done), 0);
         chk("rst_no_busy", int'(busy), 0);
      end
      tick();
      run_scn(tbl[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwconv_conv_ctrl.md
# pwconv_conv_ctrl

Sequencer for the pointwise-convolution stage of the 1×1×32 PWconv layer. It walks the 5-bit weight-SRAM address (0..31) once per input pixel and drives the SRAM enable. It also accounts for the one-cycle SRAM read latency and presents one (weight-valid, output-channel) beat per cycle to the MAC array, with downstream backpressure. It sits between the feature-vector buffer (pixel handshake) and the weight selector / MAC array, and reports per-layer start/done to the top-level scheduler.

## Interface
- NUM_OC, default 32: output channels per pixel; equals the weight SRAM depth used.
- OC_W, default 5: width of the channel/address counter; must satisfy 2^OC_W >= NUM_OC.
- PIX_W, default 16: width of the pixel counter and of num_pix.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a layer; ignored unless state is IDLE.
- num_pix  input  PIX_W  pixels in the layer; sampled on accepted start; 0 is treated as 1.
- pix_valid  input  1  feature buffer holds a pixel vector.
- pix_ready  output  1  pixel consumed; one-cycle pulse.
- w_en  output  1  weight SRAM ME.
- w_cnt  output  OC_W  weight SRAM address.
- mac_valid  output  1  SRAM Q is valid for channel mac_oc.
- mac_oc  output  OC_W  output channel of the current beat.
- mac_first  output  1  beat is channel 0 of a pixel.
- mac_last  output  1  beat is channel NUM_OC-1 of a pixel.
- out_ready  input  1  MAC array accepts the beat when mac_valid & out_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last beat of the layer is accepted.

## Operation
- State machine states: IDLE, WAIT_PIX, RUN, DRAIN, DONE.
- IDLE → WAIT_PIX on start. Latch num_pix (0 → 1). Clear pix_cnt.
- WAIT_PIX → RUN when pix_valid = 1. Clear oc_cnt.
- RUN: issue a read (w_en = 1, w_cnt = oc_cnt) when the slot is free, i.e. mac_valid = 0 or out_ready = 1.
  - On each issued read, oc_cnt increments.
  - The read of channel NUM_OC-1 moves the state to DRAIN.
- DRAIN: no reads issued. When the final beat (mac_last) is accepted:
  - pix_ready pulses in the same cycle.
  - If pix_cnt = num_pix-1 → DONE; otherwise pix_cnt increments and the state → WAIT_PIX.
- DONE: done = 1 for one cycle, then → IDLE.
- Beat register: on an issued read, mac_valid is set next cycle, and mac_oc takes the issued address.
  - Without a new read, an accepted beat clears mac_valid.
  - A stalled beat (mac_valid & !out_ready) holds mac_valid and mac_oc unchanged, with w_en = 0. With ME low, SRAM Q holds its value.
- mac_first = mac_valid & (mac_oc == 0). mac_last = mac_valid & (mac_oc == NUM_OC-1).
- w_cnt = oc_cnt when w_en = 1, otherwise 0. w_en is high only in RUN.
- oc_cnt never wraps past NUM_OC-1. pix_cnt compares against the latched num_pix-1.
- A start outside IDLE is ignored. A pix_valid drop during RUN/DRAIN is ignored, because the pixel is already committed.
- Reset at any time: state → IDLE, and all counters and registered outputs are cleared. No done is produced.

## Timing
- Reset values: w_en = 0, w_cnt = 0, mac_valid = 0, mac_oc = 0, pix_ready = 0, busy = 0, done = 0.
- start in cycle 0 → busy = 1 from cycle 1.
- With pix_valid high in cycle 1, first w_en is in cycle 2 and first mac_valid in cycle 3.
- Read latency is 1 cycle: data addressed in cycle t is marked valid in cycle t+1.
- With out_ready held high: w_en is high for NUM_OC consecutive cycles, and mac_valid is high for NUM_OC consecutive cycles, lagging by 1.
- Per-pixel throughput is NUM_OC+2 cycles: WAIT_PIX (1), RUN (NUM_OC), DRAIN (1). pix_ready is in the last DRAIN cycle.
- done pulses the cycle after the final pix_ready. IDLE and busy = 0 follow one cycle later.
- Each stall cycle of out_ready = 0 adds exactly one cycle; no beat is lost or duplicated.

## Test plan
- Single pixel, no stall: num_pix = 1, pix_valid and out_ready held high, start at cycle 0.
  - w_cnt = 0..31 on cycles 2..33, and mac_oc = 0..31 on cycles 3..34.
  - mac_first at cycle 3, mac_last and pix_ready at cycle 34, done at cycle 35, busy = 0 at cycle 36.
- Backpressure: out_ready = 0 for cycles 10..12 (beat mac_oc = 7).
  - mac_oc stays 7 and w_en = 0 for those 3 cycles, and done is delayed by exactly 3 cycles.
  - The beat sequence is still 0..31, with none missing or repeated.
- Multi-pixel with a gap: num_pix = 3, pix_valid low for 5 cycles before pixel 2.
  - Exactly 3 pix_ready pulses and 96 accepted beats, then a single done; the controller waits in WAIT_PIX for the gap.
- num_pix = 0: behaves identically to num_pix = 1 (32 beats, one done).
- start while busy is ignored: a pulse mid-RUN changes neither the counters nor the beat count.
- Reset mid-RUN: rst at mac_oc = 15 clears all outputs next cycle, and no done is produced. A fresh start then runs a full 32-beat pixel correctly.
